binary_to_bcd_hs: RTL and testbench

BINARY_TO_BCD_HS -- requirements
Module: binary_to_bcd_hs

---
 rtl/binary_to_bcd_hs_if.sv | 34 +++
 rtl/binary_to_bcd_hs.sv | 133 +++++++++++++
 tb/tb_binary_to_bcd_hs.sv | 209 ++++++++++++++++++++
 3 files changed

// File: rtl/binary_to_bcd_hs_if.sv
// Handshake bundle for binary_to_bcd_hs: the input word channel and the BCD result channel.
// blank_o is present only when BIN2BCD_LZB_EN is defined.
interface binary_to_bcd_hs_if #(
    parameter int unsigned BITS_IN_PP        = 16,
    parameter int unsigned BCD_DIGITS_OUT_PP = 5
);
    logic                           in_valid_i;
    logic                           in_ready_o;
    logic [BITS_IN_PP-1:0]          dat_binary_i;
    logic                           out_valid_o;
    logic                           out_ready_i;
    logic [4*BCD_DIGITS_OUT_PP-1:0] dat_bcd_o;
    logic                           sign_o;
    logic                           ovf_o;
`ifdef BIN2BCD_LZB_EN
    logic [BCD_DIGITS_OUT_PP-1:0]   blank_o;
`endif

    modport master (
        output in_valid_i, dat_binary_i, out_ready_i,
`ifdef BIN2BCD_LZB_EN
        input  blank_o,
`endif
        input  in_ready_o, out_valid_o, dat_bcd_o, sign_o, ovf_o
    );

    modport slave (
        input  in_valid_i, dat_binary_i, out_ready_i,
`ifdef BIN2BCD_LZB_EN
        output blank_o,
`endif
        output in_ready_o, out_valid_o, dat_bcd_o, sign_o, ovf_o
    );
endinterface

// File: rtl/binary_to_bcd_hs.sv
// Serial double-dabble binary-to-BCD converter with valid/ready handshakes on both sides.
// Optional leading-zero blanking mask (blank_o) is enabled by defining BIN2BCD_LZB_EN.
module binary_to_bcd_hs #(
    parameter int unsigned BITS_IN_PP         = 16,
    parameter int unsigned BCD_DIGITS_OUT_PP  = 5,
    parameter int unsigned SIGNED_PP          = 0,
    parameter int unsigned BIT_COUNT_WIDTH_PP = 7
) (
    input  logic              clk_i,
    input  logic              rst_n_i,
    input  logic              ce_i,
    binary_to_bcd_hs_if.slave bus
);
    localparam int unsigned BCD_W = 4 * BCD_DIGITS_OUT_PP;
    localparam logic [BIT_COUNT_WIDTH_PP-1:0] LAST_STEP = BIT_COUNT_WIDTH_PP'(BITS_IN_PP - 1);

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t                        state;
    logic [BITS_IN_PP-1:0]         mag;
    logic [BCD_W-1:0]              bcd;
    logic                          ovf;
    logic                          sign;
    logic [BIT_COUNT_WIDTH_PP-1:0] cnt;

    logic                          in_neg_c;
    logic [BITS_IN_PP-1:0]         in_mag_c;
    logic [BCD_W-1:0]              bcd_adj_c;
    logic [BCD_W-1:0]              step_bcd_c;
    logic                          step_carry_c;
    logic                          step_ovf_c;
    logic [BCD_W-1:0]              result_bcd_c;

    // Magnitude of the offered word; the most negative value maps to 2^(N-1) without wrapping.
    always_comb begin
        in_neg_c = (SIGNED_PP != 0) && bus.dat_binary_i[BITS_IN_PP-1];
        in_mag_c = bus.dat_binary_i;
        if (in_neg_c) begin
            in_mag_c = ~bus.dat_binary_i + BITS_IN_PP'(1);
        end
    end

    // One double-dabble step; a carry out of the top digit marks the result as out of range.
    always_comb begin
        bcd_adj_c = bcd;
        for (int k = 0; k < int'(BCD_DIGITS_OUT_PP); k++) begin
            if (bcd[4*k +: 4] >= 4'd5) begin
                bcd_adj_c[4*k +: 4] = bcd[4*k +: 4] + 4'd3;
            end
        end
        {step_carry_c, step_bcd_c} = {bcd_adj_c, mag[BITS_IN_PP-1]};
        step_ovf_c   = ovf | step_carry_c;
        result_bcd_c = step_ovf_c ? {BCD_DIGITS_OUT_PP{4'h9}} : step_bcd_c;
    end

`ifdef BIN2BCD_LZB_EN
    logic [BCD_DIGITS_OUT_PP-1:0] result_blank_c;
    logic                         upper_zero_c;

    // A digit blanks when it and every digit above it are zero; the units digit always shows.
    always_comb begin
        result_blank_c = '0;
        upper_zero_c   = 1'b1;
        for (int k = int'(BCD_DIGITS_OUT_PP) - 1; k >= 0; k--) begin
            upper_zero_c      = upper_zero_c & (result_bcd_c[4*k +: 4] == 4'd0);
            result_blank_c[k] = upper_zero_c;
        end
        result_blank_c[0] = 1'b0;
    end
`endif

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state           <= IDLE;
            mag             <= '0;
            bcd             <= '0;
            ovf             <= 1'b0;
            sign            <= 1'b0;
            cnt             <= '0;
            bus.in_ready_o  <= 1'b1;
            bus.out_valid_o <= 1'b0;
            bus.dat_bcd_o   <= '0;
            bus.sign_o      <= 1'b0;
            bus.ovf_o       <= 1'b0;
`ifdef BIN2BCD_LZB_EN
            bus.blank_o     <= '1;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (bus.in_valid_i) begin
                        mag            <= in_mag_c;
                        sign           <= in_neg_c;
                        bcd            <= '0;
                        ovf            <= 1'b0;
                        cnt            <= '0;
                        bus.in_ready_o <= 1'b0;
                        state          <= SHIFT;
                    end
                end
                SHIFT: begin
                    if (ce_i) begin
                        mag <= mag << 1;
                        bcd <= step_bcd_c;
                        ovf <= step_ovf_c;
                        cnt <= cnt + BIT_COUNT_WIDTH_PP'(1);
                        // Result registers only change when a conversion completes.
                        if (cnt == LAST_STEP) begin
                            bus.out_valid_o <= 1'b1;
                            bus.dat_bcd_o   <= result_bcd_c;
                            bus.sign_o      <= sign;
                            bus.ovf_o       <= step_ovf_c;
`ifdef BIN2BCD_LZB_EN
                            bus.blank_o     <= result_blank_c;
`endif
                            state           <= DONE;
                        end
                    end
                end
                DONE: begin
                    if (bus.out_ready_i) begin
                        bus.out_valid_o <= 1'b0;
                        bus.in_ready_o  <= 1'b1;
                        state           <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_binary_to_bcd_hs.sv
// Bench for binary_to_bcd_hs: unsigned, signed and 4-digit instances driven in lockstep
// and compared against a decimal-arithmetic reference model.
module tb_binary_to_bcd_hs;
    logic clk;
    logic rst_n;
    logic ce;
    int   checks   = 0;
    int   failures = 0;

    binary_to_bcd_hs_if #(.BITS_IN_PP(16), .BCD_DIGITS_OUT_PP(5)) bus_u ();
    binary_to_bcd_hs_if #(.BITS_IN_PP(16), .BCD_DIGITS_OUT_PP(5)) bus_s ();
    binary_to_bcd_hs_if #(.BITS_IN_PP(16), .BCD_DIGITS_OUT_PP(4)) bus_o ();

    binary_to_bcd_hs #(.BITS_IN_PP(16), .BCD_DIGITS_OUT_PP(5), .SIGNED_PP(0)) dut_u (
        .clk_i(clk), .rst_n_i(rst_n), .ce_i(ce), .bus(bus_u));
    binary_to_bcd_hs #(.BITS_IN_PP(16), .BCD_DIGITS_OUT_PP(5), .SIGNED_PP(1)) dut_s (
        .clk_i(clk), .rst_n_i(rst_n), .ce_i(ce), .bus(bus_s));
    binary_to_bcd_hs #(.BITS_IN_PP(16), .BCD_DIGITS_OUT_PP(4), .SIGNED_PP(0)) dut_o (
        .clk_i(clk), .rst_n_i(rst_n), .ce_i(ce), .bus(bus_o));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
        end
    endtask

    // Decimal digits by repeated division; out-of-range magnitudes read as all nines.
    function automatic logic [79:0] model_bcd(input longint unsigned value, input int nd);
        logic [79:0]      r;
        longint unsigned  lim;
        longint unsigned  v;
        r   = '0;
        lim = 1;
        v   = value;
        for (int i = 0; i < nd; i++) lim = lim * 10;
        for (int i = 0; i < nd; i++) begin
            if (value >= lim) r[4*i +: 4] = 4'd9;
            else begin
                r[4*i +: 4] = 4'(v % 10);
                v = v / 10;
            end
        end
        return r;
    endfunction

    function automatic logic [19:0] model_blank(input logic [79:0] d, input int nd);
        logic [19:0] b;
        bit          upper;
        b     = '0;
        upper = 1'b1;
        for (int k = nd - 1; k >= 0; k--) begin
            upper = upper && (d[4*k +: 4] == 4'd0);
            b[k]  = upper;
        end
        b[0] = 1'b0;
        return b;
    endfunction

    task automatic drive_in(input logic v, input logic [15:0] d);
        bus_u.in_valid_i = v; bus_u.dat_binary_i = d;
        bus_s.in_valid_i = v; bus_s.dat_binary_i = d;
        bus_o.in_valid_i = v; bus_o.dat_binary_i = d;
    endtask

    task automatic drive_ready(input logic r);
        bus_u.out_ready_i = r;
        bus_s.out_ready_i = r;
        bus_o.out_ready_i = r;
    endtask

    task automatic check_results(input string tag, input logic [15:0] x);
        logic [79:0]     eu;
        logic [79:0]     es;
        logic [79:0]     eo;
        longint unsigned mag_s;
        mag_s = x[15] ? (longint'(65536) - longint'(x)) : longint'(x);
        eu = model_bcd(longint'(x), 5);
        es = model_bcd(mag_s, 5);
        eo = model_bcd(longint'(x), 4);
        check({tag, "_u_bcd"}, 64'(bus_u.dat_bcd_o), 64'(eu[19:0]));
        check({tag, "_u_sign"}, 64'(bus_u.sign_o), 64'(0));
        check({tag, "_u_ovf"}, 64'(bus_u.ovf_o), 64'(0));
        check({tag, "_s_bcd"}, 64'(bus_s.dat_bcd_o), 64'(es[19:0]));
        check({tag, "_s_sign"}, 64'(bus_s.sign_o), 64'(x[15]));
        check({tag, "_s_ovf"}, 64'(bus_s.ovf_o), 64'(0));
        check({tag, "_o_bcd"}, 64'(bus_o.dat_bcd_o), 64'(eo[15:0]));
        check({tag, "_o_ovf"}, 64'(bus_o.ovf_o), 64'(x > 16'd9999));
`ifdef BIN2BCD_LZB_EN
        check({tag, "_u_blank"}, 64'(bus_u.blank_o), 64'(model_blank(eu, 5) & 20'h1f));
        check({tag, "_s_blank"}, 64'(bus_s.blank_o), 64'(model_blank(es, 5) & 20'h1f));
        check({tag, "_o_blank"}, 64'(bus_o.blank_o), 64'(model_blank(eo, 4) & 20'hf));
`endif
    endtask

    task automatic check_handshake(input string tag, input logic rdy, input logic vld);
        check({tag, "_in_ready"}, 64'({bus_u.in_ready_o, bus_s.in_ready_o, bus_o.in_ready_o}),
              64'({3{rdy}}));
        check({tag, "_out_valid"}, 64'({bus_u.out_valid_o, bus_s.out_valid_o, bus_o.out_valid_o}),
              64'({3{vld}}));
    endtask

    task automatic check_reset_values(input string tag);
        check_handshake(tag, 1'b1, 1'b0);
        check({tag, "_bcd"}, 64'({bus_u.dat_bcd_o, bus_s.dat_bcd_o, bus_o.dat_bcd_o}), 64'(0));
        check({tag, "_flags"}, 64'({bus_u.sign_o, bus_u.ovf_o, bus_s.sign_o, bus_s.ovf_o,
                                    bus_o.sign_o, bus_o.ovf_o}), 64'(0));
`ifdef BIN2BCD_LZB_EN
        check({tag, "_blank"}, 64'({bus_u.blank_o, bus_s.blank_o, bus_o.blank_o}), 64'(14'h3fff));
`endif
    endtask

    // One transaction: accept, shift (ce constant or random), optional backpressure, release.
    task automatic convert(input logic [15:0] x, input bit ce_rand, input int hold);
        int edges;
        int en;
        bit seen;
        @(negedge clk);
        check_handshake("pre_accept", 1'b1, 1'b0);
        drive_in(1'b1, x);
        drive_ready(1'b0);
        ce = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check_handshake("shifting", 1'b0, 1'b0);
        edges = 1;
        en    = 1;
        seen  = 1'b0;
        drive_in(1'b1, 16'($urandom));
        for (int i = 0; i < 400 && !seen; i++) begin
            ce = ce_rand ? 1'($urandom_range(0, 1)) : 1'b1;
            @(posedge clk);
            edges++;
            if (ce) en++;
            @(negedge clk);
            if (bus_u.out_valid_o) seen = 1'b1;
        end
        ce = 1'b1;
        check("result_seen", 64'(seen), 64'(1));
        if (!ce_rand) check("latency_edges", 64'(edges - 1), 64'(16));
        check("enabled_edges", 64'(en - 1), 64'(16));
        check_handshake("done", 1'b0, 1'b1);
        check_results("done", x);
        for (int h = 0; h < hold; h++) begin
            drive_in(1'b1, 16'($urandom));
            @(posedge clk);
            @(negedge clk);
            check_handshake("hold", 1'b0, 1'b1);
            check_results("hold", x);
        end
        drive_in(1'b0, 16'($urandom));
        drive_ready(1'b1);
        @(posedge clk);
        @(negedge clk);
        drive_ready(1'b0);
        check_handshake("idle", 1'b1, 1'b0);
        check_results("idle", x);
    endtask

    initial begin
        rst_n = 1'b0;
        ce    = 1'b1;
        drive_in(1'b0, 16'd0);
        drive_ready(1'b0);
        #12;
        check_reset_values("reset");
        @(negedge clk);
        rst_n = 1'b1;

        convert(16'd12345, 1'b0, 0);
        convert(16'hFFFF, 1'b0, 10);
        convert(16'h8000, 1'b0, 0);
        convert(16'd0, 1'b0, 0);
        convert(16'd42, 1'b0, 0);
        convert(16'd9999, 1'b0, 0);
        convert(16'd10000, 1'b0, 2);
        convert(16'd65535, 1'b1, 0);
        convert(16'h7FFF, 1'b1, 1);
        for (int n = 0; n < 20; n++) begin
            convert(16'($urandom), 1'($urandom_range(0, 1)), int'($urandom_range(0, 3)));
        end

        // Abort a conversion part-way through the shift phase.
        convert(16'd4321, 1'b0, 0);
        @(negedge clk);
        drive_in(1'b1, 16'd5555);
        ce = 1'b1;
        @(posedge clk);
        @(negedge clk);
        drive_in(1'b0, 16'd0);
        repeat (6) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_values("mid_reset");
        @(negedge clk);
        check_reset_values("mid_reset_held");
        rst_n = 1'b1;
        convert(16'd999, 1'b0, 0);
        check("bcd_999", 64'(bus_u.dat_bcd_o), 64'(20'h00999));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
